// File: rtl/sv32_tlb_pkg.sv
// rtl/sv32_tlb_pkg.sv - shared TLB types, flag layout and FSM encoding
package sv32_tlb_pkg;

  localparam int TLB_FLAGS_WD = 8;

  // PTE flag bit positions within {D,A,G,U,X,W,R,V}
  localparam int FLAG_V = 0;
  localparam int FLAG_R = 1;
  localparam int FLAG_W = 2;
  localparam int FLAG_X = 3;
  localparam int FLAG_U = 4;
  localparam int FLAG_G = 5;
  localparam int FLAG_A = 6;
  localparam int FLAG_D = 7;

  // Default Sv32 field widths
  localparam int TLB_ASID_WD = 9;
  localparam int TLB_VPN1_WD = 10;
  localparam int TLB_VPN0_WD = 10;
  localparam int TLB_PPN_WD  = 22;

  // Entry layout at the default Sv32 widths; the TLB mirrors it with its own widths
  typedef struct packed {
    logic                    v;
    logic                    super_pg;
    logic [TLB_ASID_WD-1:0]  asid;
    logic [TLB_VPN1_WD-1:0]  vpn1;
    logic [TLB_VPN0_WD-1:0]  vpn0;
    logic [TLB_PPN_WD-1:0]   ppn;
    logic [TLB_FLAGS_WD-1:0] flags;
  } tlb_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tlb_state_t;

endpackage

// File: rtl/sv32_tlb_victim_sel.sv
// rtl/sv32_tlb_victim_sel.sv - fill slot choice: lowest invalid entry, else round-robin pointer
module tlb_victim_sel
  import sv32_tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  localparam int IDX_WD = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [IDX_WD-1:0]  rr_ptr,
  output logic [IDX_WD-1:0]  victim_idx,
  output logic               evict,
  output logic [IDX_WD-1:0]  rr_next
);

  // Scan downward so the lowest free slot is the last one written
  always_comb begin
    victim_idx = rr_ptr;
    evict      = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim_idx = IDX_WD'(i);
        evict      = 1'b0;
      end
    end
    rr_next = (rr_ptr == IDX_WD'(ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
  end

endmodule

// File: rtl/sv32_tlb.sv
// rtl/sv32_tlb.sv - fully associative Sv32 TLB with fill, lookup and SFENCE.VMA flush
module sv32_tlb
  import sv32_tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int ASID_WD = 9,
  parameter int VPN1_WD = 10,
  parameter int VPN0_WD = 10,
  parameter int PPN_WD  = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lkp_valid_i,
  output logic                       lkp_ready_o,
  input  logic [VPN1_WD+VPN0_WD-1:0] lkp_vpn_i,
  input  logic [ASID_WD-1:0]         lkp_asid_i,
  output logic                       lkp_rvalid_o,
  output logic                       lkp_hit_o,
  output logic [PPN_WD-1:0]          lkp_ppn_o,
  output logic [TLB_FLAGS_WD-1:0]    lkp_flags_o,
  input  logic                       fill_valid_i,
  output logic                       fill_ready_o,
  input  logic [VPN1_WD+VPN0_WD-1:0] fill_vpn_i,
  input  logic [ASID_WD-1:0]         fill_asid_i,
  input  logic [PPN_WD-1:0]          fill_ppn_i,
  input  logic [TLB_FLAGS_WD-1:0]    fill_flags_i,
  input  logic                       fill_super_i,
  input  logic                       flush_valid_i,
  output logic                       flush_ready_o,
  input  logic                       flush_va_en_i,
  input  logic                       flush_asid_en_i,
  input  logic [VPN1_WD+VPN0_WD-1:0] flush_vpn_i,
  input  logic [ASID_WD-1:0]         flush_asid_i,
  output logic                       flush_done_o
);

  localparam int IDX_WD = $clog2(ENTRIES);
  localparam int VPN_WD = VPN1_WD + VPN0_WD;
  localparam logic [PPN_WD-1:0] VPN0_MASK = PPN_WD'((64'd1 << VPN0_WD) - 64'd1);

  typedef struct packed {
    logic                    v;
    logic                    super_pg;
    logic [ASID_WD-1:0]      asid;
    logic [VPN1_WD-1:0]      vpn1;
    logic [VPN0_WD-1:0]      vpn0;
    logic [PPN_WD-1:0]       ppn;
    logic [TLB_FLAGS_WD-1:0] flags;
  } entry_t;

  entry_t              tlb_q [ENTRIES];
  tlb_state_t          state_q, state_d;
  logic [IDX_WD-1:0]   rr_q;
  logic                fq_va_en, fq_asid_en;
  logic [VPN_WD-1:0]   fq_vpn;
  logic [ASID_WD-1:0]  fq_asid;

  logic                flush_acc, fill_acc, lkp_acc;
  logic                lkp_hit, fill_hit, victim_evict;
  logic [IDX_WD-1:0]   lkp_idx, fill_hit_idx, victim_idx, rr_next, fill_idx;
  logic [ENTRIES-1:0]  valid_vec, flush_kill;
  entry_t              lkp_e;
  logic [PPN_WD-1:0]   lkp_ppn;

  // Readies and done are held low during reset so every output reads 0
  always_comb begin
    flush_ready_o = rst && (state_q == ST_IDLE);
    fill_ready_o  = flush_ready_o && !flush_valid_i;
    lkp_ready_o   = fill_ready_o && !fill_valid_i;
    flush_done_o  = rst && (state_q == ST_FLUSH);
    flush_acc     = flush_valid_i && flush_ready_o;
    fill_acc      = fill_valid_i && fill_ready_o;
    lkp_acc       = lkp_valid_i && lkp_ready_o;
  end

  // FLUSH always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_acc) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Associative compares for lookup, fill-rewrite and flush; downward scans give lowest-index priority
  always_comb begin
    lkp_hit      = 1'b0;
    lkp_idx      = '0;
    fill_hit     = 1'b0;
    fill_hit_idx = '0;
    valid_vec    = '0;
    flush_kill   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      valid_vec[i] = tlb_q[i].v;
      if (tlb_q[i].v && (tlb_q[i].flags[FLAG_G] || tlb_q[i].asid == lkp_asid_i) &&
          tlb_q[i].vpn1 == lkp_vpn_i[VPN_WD-1:VPN0_WD] &&
          (tlb_q[i].super_pg || tlb_q[i].vpn0 == lkp_vpn_i[VPN0_WD-1:0])) begin
        lkp_hit = 1'b1;
        lkp_idx = IDX_WD'(i);
      end
      if (tlb_q[i].v && tlb_q[i].asid == fill_asid_i && tlb_q[i].super_pg == fill_super_i &&
          tlb_q[i].vpn1 == fill_vpn_i[VPN_WD-1:VPN0_WD] &&
          (fill_super_i || tlb_q[i].vpn0 == fill_vpn_i[VPN0_WD-1:0])) begin
        fill_hit     = 1'b1;
        fill_hit_idx = IDX_WD'(i);
      end
      flush_kill[i] = (!fq_va_en || (tlb_q[i].vpn1 == fq_vpn[VPN_WD-1:VPN0_WD] &&
                        (tlb_q[i].super_pg || tlb_q[i].vpn0 == fq_vpn[VPN0_WD-1:0]))) &&
                      (!fq_asid_en || (!tlb_q[i].flags[FLAG_G] && tlb_q[i].asid == fq_asid));
    end
    lkp_e    = tlb_q[lkp_idx];
    lkp_ppn  = lkp_e.super_pg ? ((lkp_e.ppn & ~VPN0_MASK) | PPN_WD'(lkp_vpn_i[VPN0_WD-1:0]))
                              : lkp_e.ppn;
    fill_idx = fill_hit ? fill_hit_idx : victim_idx;
  end

  tlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
    .valid      (valid_vec),
    .rr_ptr     (rr_q),
    .victim_idx (victim_idx),
    .evict      (victim_evict),
    .rr_next    (rr_next)
  );

  // Entry array: flush invalidates on leaving FLUSH, fills write at their accept edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) tlb_q[i] <= '0;
    end else if (state_q == ST_FLUSH) begin
      for (int i = 0; i < ENTRIES; i++) if (flush_kill[i]) tlb_q[i].v <= 1'b0;
    end else if (fill_acc) begin
      tlb_q[fill_idx] <= '{v: 1'b1, super_pg: fill_super_i, asid: fill_asid_i,
                           vpn1: fill_vpn_i[VPN_WD-1:VPN0_WD], vpn0: fill_vpn_i[VPN0_WD-1:0],
                           ppn: fill_ppn_i, flags: fill_flags_i};
    end
  end

  // FSM state, flush filter capture and replacement pointer (moves only on evictions)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      fq_va_en   <= 1'b0;
      fq_asid_en <= 1'b0;
      fq_vpn     <= '0;
      fq_asid    <= '0;
    end else begin
      state_q <= state_d;
      if (flush_acc) begin
        fq_va_en   <= flush_va_en_i;
        fq_asid_en <= flush_asid_en_i;
        fq_vpn     <= flush_vpn_i;
        fq_asid    <= flush_asid_i;
      end
      if (fill_acc && !fill_hit && victim_evict) rr_q <= rr_next;
    end
  end

  // Registered lookup response, present for exactly one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lkp_rvalid_o <= 1'b0;
      lkp_hit_o    <= 1'b0;
      lkp_ppn_o    <= '0;
      lkp_flags_o  <= '0;
    end else begin
      lkp_rvalid_o <= lkp_acc;
      lkp_hit_o    <= lkp_acc && lkp_hit;
      lkp_ppn_o    <= (lkp_acc && lkp_hit) ? lkp_ppn : '0;
      lkp_flags_o  <= (lkp_acc && lkp_hit) ? lkp_e.flags : '0;
    end
  end

endmodule

// File: tb/tb_sv32_tlb.sv
// tb/tb_sv32_tlb.sv - directed self-checking bench for sv32_tlb
module tb_sv32_tlb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lkp_valid = 1'b0, lkp_ready;
  logic [19:0] lkp_vpn = '0;
  logic [8:0]  lkp_asid = '0;
  logic        lkp_rvalid, lkp_hit;
  logic [21:0] lkp_ppn;
  logic [7:0]  lkp_flags;
  logic        fill_valid = 1'b0, fill_ready;
  logic [19:0] fill_vpn = '0;
  logic [8:0]  fill_asid = '0;
  logic [21:0] fill_ppn = '0;
  logic [7:0]  fill_flags = '0;
  logic        fill_super = 1'b0;
  logic        flush_valid = 1'b0, flush_ready;
  logic        flush_va_en = 1'b0, flush_asid_en = 1'b0;
  logic [19:0] flush_vpn = '0;
  logic [8:0]  flush_asid = '0;
  logic        flush_done;

  int checks = 0;
  int errors = 0;

  sv32_tlb dut (
    .clk(clk), .rst(rst),
    .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_vpn_i(lkp_vpn), .lkp_asid_i(lkp_asid),
    .lkp_rvalid_o(lkp_rvalid), .lkp_hit_o(lkp_hit), .lkp_ppn_o(lkp_ppn), .lkp_flags_o(lkp_flags),
    .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_vpn_i(fill_vpn),
    .fill_asid_i(fill_asid), .fill_ppn_i(fill_ppn), .fill_flags_i(fill_flags),
    .fill_super_i(fill_super),
    .flush_valid_i(flush_valid), .flush_ready_o(flush_ready), .flush_va_en_i(flush_va_en),
    .flush_asid_en_i(flush_asid_en), .flush_vpn_i(flush_vpn), .flush_asid_i(flush_asid),
    .flush_done_o(flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [19:0] vpn, input logic [8:0] asid,
                        input logic hit, input logic [21:0] ppn, input logic [7:0] flags);
    lkp_valid = 1'b1; lkp_vpn = vpn; lkp_asid = asid;
    #1;
    chk({tag, ".ready"}, lkp_ready, 1'b1);
    tick;
    lkp_valid = 1'b0;
    chk({tag, ".rvalid"}, lkp_rvalid, 1'b1);
    chk({tag, ".hit"}, lkp_hit, hit);
    chk({tag, ".ppn"}, lkp_ppn, ppn);
    chk({tag, ".flags"}, lkp_flags, flags);
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                      input logic [7:0] flags, input logic sup);
    fill_valid = 1'b1; fill_vpn = vpn; fill_asid = asid;
    fill_ppn = ppn; fill_flags = flags; fill_super = sup;
    tick;
    fill_valid = 1'b0;
  endtask

  task automatic flush(input string tag, input logic va_en, input logic asid_en,
                       input logic [19:0] vpn, input logic [8:0] asid);
    flush_valid = 1'b1; flush_va_en = va_en; flush_asid_en = asid_en;
    flush_vpn = vpn; flush_asid = asid;
    tick;
    flush_valid = 1'b0;
    chk({tag, ".done"}, flush_done, 1'b1);
    chk({tag, ".flush_ready_in_flush"}, flush_ready, 1'b0);
    chk({tag, ".fill_ready_in_flush"}, fill_ready, 1'b0);
    chk({tag, ".lkp_ready_in_flush"}, lkp_ready, 1'b0);
    tick;
    chk({tag, ".done_drop"}, flush_done, 1'b0);
    chk({tag, ".flush_ready_idle"}, flush_ready, 1'b1);
  endtask

  initial begin
    // Reset state: everything low while rst is asserted
    #2;
    chk("rst.lkp_ready", lkp_ready, 1'b0);
    chk("rst.fill_ready", fill_ready, 1'b0);
    chk("rst.flush_ready", flush_ready, 1'b0);
    chk("rst.rvalid", lkp_rvalid, 1'b0);
    chk("rst.done", flush_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 1: empty table misses
    lookup("t1.empty", 20'h12345, 9'd1, 1'b0, 22'h0, 8'h00);
    tick;
    chk("t1.rvalid_one_cycle", lkp_rvalid, 1'b0);

    // 2: 4 KiB page fill, ASID sensitivity
    fill(20'h12345, 9'd1, 22'h0ABCD, 8'h0F, 1'b0);
    lookup("t2.hit", 20'h12345, 9'd1, 1'b1, 22'h0ABCD, 8'h0F);
    lookup("t2.other_asid", 20'h12345, 9'd2, 1'b0, 22'h0, 8'h00);

    // 3: global megapage, vpn0 passes through to the PPN
    fill(20'h12000, 9'd3, 22'h3FF000, 8'h2F, 1'b1);
    lookup("t3.mega", 20'h12177, 9'd5, 1'b1, 22'h3FF177, 8'h2F);

    // Global flush also removes G entries
    flush("fl_all", 1'b0, 1'b0, 20'h0, 9'd0);
    lookup("fl_all.page", 20'h12345, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("fl_all.mega", 20'h12177, 9'd5, 1'b0, 22'h0, 8'h00);

    // 4: fill every slot, then evict round-robin from 0
    for (int i = 0; i < 32; i++) fill(20'h00100 + 20'(i), 9'd1, 22'h01000 + 22'(i), 8'h0F, 1'b0);
    for (int j = 0; j < 3; j++)  fill(20'h00200 + 20'(j), 9'd1, 22'h02000 + 22'(j), 8'h0F, 1'b0);
    lookup("t4.q0", 20'h00200, 9'd1, 1'b1, 22'h02000, 8'h0F);
    lookup("t4.q2", 20'h00202, 9'd1, 1'b1, 22'h02002, 8'h0F);
    lookup("t4.p0_evicted", 20'h00100, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("t4.p1_evicted", 20'h00101, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("t4.p2_evicted", 20'h00102, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("t4.p3_kept", 20'h00103, 9'd1, 1'b1, 22'h01003, 8'h0F);
    lookup("t4.p31_kept", 20'h0011F, 9'd1, 1'b1, 22'h0101F, 8'h0F);

    // Pointer continues at 3, then 4; rewriting a present tag reuses its slot
    fill(20'h00300, 9'd7, 22'h03000, 8'h2F, 1'b0);
    fill(20'h00400, 9'd2, 22'h04000, 8'h0F, 1'b0);
    fill(20'h00300, 9'd7, 22'h03333, 8'h2F, 1'b0);
    lookup("t4.p3_evicted", 20'h00103, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("t4.p4_evicted", 20'h00104, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("t4.p5_kept", 20'h00105, 9'd1, 1'b1, 22'h01005, 8'h0F);
    lookup("t4.rewrite", 20'h00300, 9'd7, 1'b1, 22'h03333, 8'h2F);

    // 5: ASID flush spares G entries and other ASIDs
    flush("t5.asid", 1'b0, 1'b1, 20'h0, 9'd1);
    lookup("t5.p5_gone", 20'h00105, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("t5.q1_gone", 20'h00201, 9'd1, 1'b0, 22'h0, 8'h00);
    lookup("t5.g_kept", 20'h00300, 9'd1, 1'b1, 22'h03333, 8'h2F);
    lookup("t5.asid2_kept", 20'h00400, 9'd2, 1'b1, 22'h04000, 8'h0F);

    // Address flush without ASID filter
    flush("t5.va", 1'b1, 1'b0, 20'h00400, 9'd0);
    lookup("t5.va_gone", 20'h00400, 9'd2, 1'b0, 22'h0, 8'h00);
    lookup("t5.va_other_kept", 20'h00300, 9'd7, 1'b1, 22'h03333, 8'h2F);

    // 6a: simultaneous requests, only the flush is taken
    flush_valid = 1'b1; flush_va_en = 1'b1; flush_asid_en = 1'b0; flush_vpn = 20'h00777;
    fill_valid = 1'b1; fill_vpn = 20'h00500; fill_asid = 9'd1; fill_ppn = 22'h05000;
    fill_flags = 8'h0F; fill_super = 1'b0;
    lkp_valid = 1'b1; lkp_vpn = 20'h00300; lkp_asid = 9'd7;
    #1;
    chk("t6.flush_ready", flush_ready, 1'b1);
    chk("t6.fill_ready", fill_ready, 1'b0);
    chk("t6.lkp_ready", lkp_ready, 1'b0);
    tick;
    flush_valid = 1'b0; fill_valid = 1'b0; lkp_valid = 1'b0;
    chk("t6.no_rvalid", lkp_rvalid, 1'b0);
    chk("t6.done", flush_done, 1'b1);
    tick;
    lookup("t6.fill_dropped", 20'h00500, 9'd1, 1'b0, 22'h0, 8'h00);

    // 6b: reset while in FLUSH
    flush_valid = 1'b1; flush_va_en = 1'b1; flush_asid_en = 1'b0; flush_vpn = 20'h00777;
    tick;
    flush_valid = 1'b0;
    chk("t6.in_flush", flush_done, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6.rst_done", flush_done, 1'b0);
    chk("t6.rst_flush_ready", flush_ready, 1'b0);
    chk("t6.rst_fill_ready", fill_ready, 1'b0);
    chk("t6.rst_lkp_ready", lkp_ready, 1'b0);
    chk("t6.rst_rvalid", lkp_rvalid, 1'b0);
    tick;
    chk("t6.rst_hold_done", flush_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk("t6.post_rst_done", flush_done, 1'b0);
    chk("t6.post_rst_idle", flush_ready, 1'b1);
    lookup("t6.table_empty", 20'h00300, 9'd7, 1'b0, 22'h0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
